// File: rtl/hs_pkg.sv
// Shared definitions for the req/gnt handshake responder: FSM states and
// latency bounds used by the top and its latency counter.
package hs_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        GRANT = 2'd2
    } hs_state_e;

    localparam int LAT_MIN = 1;
    localparam int LAT_MAX = 15;
    localparam int LAT_W   = 4;

endpackage

// File: rtl/hs_lat_counter.sv
// Loadable down-counter that times the gap between request acceptance and
// grant; hit marks the last waiting cycle.
module hs_lat_counter
    import hs_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             dec,
    input  logic [LAT_W-1:0] load_val,
    output logic             hit
);

    logic [LAT_W-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (dec && (cnt != '0)) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign hit = (cnt == LAT_W'(1));

endmodule

// File: rtl/req_gnt_responder.sv
// Responder end of the req/gnt handshake: one outstanding request, grant
// exactly LATENCY edges after acceptance, sticky violation flag and counters.
module req_gnt_responder
    import hs_pkg::*;
#(
    parameter int LATENCY = 3,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             req,
    input  logic             clr_err,
    output logic             gnt,
    output logic             busy,
    output logic             err,
    output logic [CNT_W-1:0] req_cnt,
    output logic [CNT_W-1:0] gnt_cnt
);

    if ((LATENCY < LAT_MIN) || (LATENCY > LAT_MAX)) begin : g_bad_latency
        $error("req_gnt_responder: LATENCY must be within 1..15");
    end

    localparam logic [LAT_W-1:0] LOAD_VAL = LAT_W'(LATENCY - 1);

    hs_state_e state;
    hs_state_e state_nxt;
    logic      accept;
    logic      violation;
    logic      lat_load;
    logic      lat_dec;
    logic      lat_hit;

    hs_lat_counter u_lat_counter (
        .clk      (clk),
        .rst      (rst),
        .load     (lat_load),
        .dec      (lat_dec),
        .load_val (LOAD_VAL),
        .hit      (lat_hit)
    );

    // GRANT accepts a new request exactly like IDLE, giving back-to-back service
    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        violation = 1'b0;
        lat_load  = 1'b0;
        lat_dec   = 1'b0;
        case (state)
            IDLE, GRANT: begin
                state_nxt = IDLE;
                if (req && en) begin
                    accept = 1'b1;
                    if (LATENCY == 1) begin
                        state_nxt = GRANT;
                    end else begin
                        state_nxt = WAIT;
                        lat_load  = 1'b1;
                    end
                end
            end
            WAIT: begin
                violation = req && en;
                if (lat_hit) begin
                    state_nxt = GRANT;
                end else begin
                    lat_dec = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // gnt and busy are flops of their own so the outputs never glitch on state decode
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            gnt     <= 1'b0;
            busy    <= 1'b0;
            err     <= 1'b0;
            req_cnt <= '0;
            gnt_cnt <= '0;
        end else begin
            state <= state_nxt;
            gnt   <= (state_nxt == GRANT);
            busy  <= (state_nxt != IDLE);
            if (violation) begin
                err <= 1'b1;
            end else if (clr_err) begin
                err <= 1'b0;
            end
            if (accept) begin
                req_cnt <= req_cnt + 1'b1;
            end
            if (state == GRANT) begin
                gnt_cnt <= gnt_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_req_gnt_responder.sv
// Self-checking bench: LATENCY=3 and LATENCY=1 responders driven in lockstep,
// compared every cycle against a grant-time reference model.
module tb_req_gnt_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        req;
    logic        clr_err;
    logic        gnt_w     [2];
    logic        busy_w    [2];
    logic        err_w     [2];
    logic [15:0] req_cnt_w [2];
    logic [15:0] gnt_cnt_w [2];

    int          errors = 0;
    int          checks = 0;
    int          k;
    int          lat [2];
    int          due [2];
    logic [15:0] m_req [2];
    logic [15:0] m_gnt [2];
    logic        m_err [2];

    always #5 clk = ~clk;

    req_gnt_responder #(.LATENCY(3), .CNT_W(16)) dut_lat3 (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .req     (req),
        .clr_err (clr_err),
        .gnt     (gnt_w[0]),
        .busy    (busy_w[0]),
        .err     (err_w[0]),
        .req_cnt (req_cnt_w[0]),
        .gnt_cnt (gnt_cnt_w[0])
    );

    req_gnt_responder #(.LATENCY(1), .CNT_W(16)) dut_lat1 (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .req     (req),
        .clr_err (clr_err),
        .gnt     (gnt_w[1]),
        .busy    (busy_w[1]),
        .err     (err_w[1]),
        .req_cnt (req_cnt_w[1]),
        .gnt_cnt (gnt_cnt_w[1])
    );

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Model tracks only the edge at which each in-flight grant is due
    task automatic modelReset();
        for (int i = 0; i < 2; i++) begin
            due[i]   = -1;
            m_req[i] = '0;
            m_gnt[i] = '0;
            m_err[i] = 1'b0;
        end
    endtask

    task automatic modelStep(input logic r, input logic e, input logic c);
        for (int i = 0; i < 2; i++) begin
            bit outstanding;
            outstanding = (due[i] > k);
            if (due[i] == k) m_gnt[i] = m_gnt[i] + 16'd1;
            if (r && e && outstanding) begin
                m_err[i] = 1'b1;
            end else begin
                if (c) m_err[i] = 1'b0;
                if (r && e) begin
                    m_req[i] = m_req[i] + 16'd1;
                    due[i]   = k + lat[i];
                end
            end
        end
    endtask

    task automatic checkAll();
        for (int i = 0; i < 2; i++) begin
            checkOutput($sformatf("L%0d gnt e%0d", lat[i], k), 32'(gnt_w[i]), 32'(due[i] == k));
            checkOutput($sformatf("L%0d busy e%0d", lat[i], k), 32'(busy_w[i]), 32'(due[i] >= k));
            checkOutput($sformatf("L%0d err e%0d", lat[i], k), 32'(err_w[i]), 32'(m_err[i]));
            checkOutput($sformatf("L%0d req_cnt e%0d", lat[i], k), 32'(req_cnt_w[i]), 32'(m_req[i]));
            checkOutput($sformatf("L%0d gnt_cnt e%0d", lat[i], k), 32'(gnt_cnt_w[i]), 32'(m_gnt[i]));
        end
    endtask

    // Called at a falling edge; returns at the next falling edge
    task automatic applyStimulus(input logic r, input logic e, input logic c);
        req     = r;
        en      = e;
        clr_err = c;
        checkAll();
        @(posedge clk);
        modelStep(r, e, c);
        k++;
        @(negedge clk);
    endtask

    task automatic applyReset();
        req     = 1'b0;
        en      = 1'b0;
        clr_err = 1'b0;
        #1;
        rst = 1'b1;
        #1;
        modelReset();
        for (int i = 0; i < 2; i++) begin
            checkOutput($sformatf("L%0d async gnt", lat[i]), 32'(gnt_w[i]), 32'd0);
            checkOutput($sformatf("L%0d async busy", lat[i]), 32'(busy_w[i]), 32'd0);
            checkOutput($sformatf("L%0d async err", lat[i]), 32'(err_w[i]), 32'd0);
        end
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        lat[0]  = 3;
        lat[1]  = 1;
        rst     = 1'b1;
        req     = 1'b0;
        en      = 1'b0;
        clr_err = 1'b0;
        k       = 1;
        modelReset();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Single request
        applyStimulus(1, 1, 0);
        repeat (5) applyStimulus(0, 1, 0);

        // Requests every third edge, landing on the LATENCY=3 grant edge
        for (int n = 0; n < 9; n++) applyStimulus(n % 3 == 0, 1, 0);
        repeat (5) applyStimulus(0, 1, 0);

        // Request during WAIT, then clear
        applyStimulus(1, 1, 0);
        applyStimulus(1, 1, 0);
        repeat (3) applyStimulus(0, 1, 0);
        applyStimulus(0, 1, 1);
        repeat (3) applyStimulus(0, 1, 0);

        // Enable gating, and en dropped after acceptance
        applyStimulus(1, 0, 0);
        repeat (3) applyStimulus(0, 0, 0);
        applyStimulus(1, 1, 0);
        repeat (5) applyStimulus(0, 0, 0);

        // Reset with a grant in flight
        applyStimulus(1, 1, 0);
        applyStimulus(0, 1, 0);
        applyReset();
        repeat (2) applyStimulus(0, 1, 0);
        applyStimulus(1, 1, 0);
        repeat (5) applyStimulus(0, 1, 0);

        // Consecutive requests
        repeat (3) applyStimulus(1, 1, 0);
        repeat (4) applyStimulus(0, 1, 0);

        for (int n = 0; n < 1500; n++) begin
            if ($urandom_range(0, 199) == 0) begin
                applyReset();
            end else begin
                applyStimulus($urandom_range(0, 99) < 40, $urandom_range(0, 99) < 80,
                              $urandom_range(0, 99) < 10);
            end
        end

        // Counter wrap: LATENCY=1 accepts on every edge
        applyReset();
        repeat (65540) applyStimulus(1, 1, 0);
        repeat (4) applyStimulus(0, 1, 0);
        checkAll();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
